// File: rtl/frame_writer_pkg.sv
// Shared types and frame geometry for the frame writer.
// Holds the FSM encoding and the default framebuffer size.
package frame_writer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2
  } fw_state_e;

  localparam int unsigned FRAME_W_DEF  = 256;
  localparam int unsigned FRAME_H_DEF  = 240;
  localparam int unsigned FRAME_PIXELS = FRAME_W_DEF * FRAME_H_DEF;
  localparam int unsigned ADDR_W       = 16;

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer: one write port, one registered
// read-first read port, written to infer block RAM.
module fb_ram
  import frame_writer_pkg::*;
#(
  parameter int unsigned DEPTH  = FRAME_PIXELS,
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read and write in one block so a same-address access sees old data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
    rdata_q <= mem[raddr[IDX_W-1:0]];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/frame_writer.sv
// Capture-stream to framebuffer writer: SOF-aligned FSM, write
// address counter, done/overflow flags and masked read port.
module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int unsigned FRAME_W = FRAME_W_DEF,
  parameter int unsigned FRAME_H = FRAME_H_DEF,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              vga_clk_25,
  input  logic              reset,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_valid,
  input  logic              pix_sof,
  output logic              pix_ready,
  input  logic              capture_en,
  input  logic [15:0]       rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_done,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned PIXELS = FRAME_W * FRAME_H;
  localparam logic [15:0] LAST   = 16'(PIXELS - 1);
  localparam logic [16:0] LIMIT  = 17'(PIXELS);

  fw_state_e state_q, state_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic ovf_q, ovf_d;
  logic done_q, done_d;
  logic ready_q;
  logic rd_ok_q, rd_ok_d;

  logic              xfer;
  logic              we;
  logic [15:0]       waddr;
  logic [DATA_W-1:0] ram_rdata;

  assign xfer    = pix_valid & ready_q;
  assign rd_ok_d = ({1'b0, rd_addr} < LIMIT);

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    we        = 1'b0;
    waddr     = wr_addr_q;
    unique case (state_q)
      IDLE: begin
        if (capture_en) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (!capture_en) begin
          state_d = IDLE;
        end else if (xfer && pix_sof) begin
          we        = 1'b1;
          waddr     = '0;
          wr_addr_d = 16'd1;
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        if (xfer) begin
          we = 1'b1;
          // Early SOF: short frame, resync on the new one.
          if (pix_sof && wr_addr_q != '0) begin
            ovf_d     = 1'b1;
            waddr     = '0;
            wr_addr_d = 16'd1;
          end else if (wr_addr_q == LAST) begin
            done_d    = 1'b1;
            wr_addr_d = '0;
            state_d   = capture_en ? WAIT_SOF : IDLE;
          end else begin
            wr_addr_d = wr_addr_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk_25 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      rd_ok_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      ready_q   <= 1'b1;
      rd_ok_q   <= rd_ok_d;
    end
  end

  fb_ram #(
    .DEPTH  (PIXELS),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (vga_clk_25),
    .we    (we),
    .waddr (waddr),
    .wdata (pix_data),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  assign rd_data    = rd_ok_q ? ram_rdata : '0;
  assign pix_ready  = ready_q;
  assign frame_done = done_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q == CAPTURE);

endmodule

// File: tb/tb_frame_writer.sv
// Scoreboard bench for frame_writer on a reduced 32x16 frame.
// Reads and frame_done pulses are checked by a separate monitor.
module tb_frame_writer;

  localparam int FW   = 32;
  localparam int FH   = 16;
  localparam int NPIX = FW * FH;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_sof;
  logic        pix_ready;
  logic        capture_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        frame_done;
  logic        overflow;
  logic        busy;

  always #20 clk = ~clk;

  frame_writer #(
    .FRAME_W (FW),
    .FRAME_H (FH),
    .DATA_W  (8)
  ) dut (
    .vga_clk_25 (clk),
    .reset      (reset),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_ready  (pix_ready),
    .capture_en (capture_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_done (frame_done),
    .overflow   (overflow),
    .busy       (busy)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } rd_exp_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  rd_exp_t     rd_q[$];
  int unsigned done_q[$];
  logic        rd_chk = 1'b0;
  logic        rd_pend = 1'b0;
  rd_exp_t     mon_e;
  int unsigned mon_c;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_pend <= rd_chk;
  end

  always @(negedge clk) begin
    if (rd_pend) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got 0x%0h, nothing expected", rd_data);
      end else begin
        mon_e = rd_q.pop_front();
        if (rd_data !== mon_e.data) begin
          errors++;
          $display("FAIL rd[0x%0h]: got 0x%0h expected 0x%0h",
                   mon_e.addr, rd_data, mon_e.data);
        end
      end
    end
    if (frame_done !== 1'b0) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL frame_done: got %b at cycle %0d, expected no pulse",
                 frame_done, cyc);
      end else begin
        mon_c = done_q.pop_front();
        if (cyc != mon_c || frame_done !== 1'b1) begin
          errors++;
          $display("FAIL frame_done_cycle: got cycle %0d expected cycle %0d",
                   cyc, mon_c);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] d, input logic sof);
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp);
    rd_addr = a;
    rd_chk  = 1'b1;
    rd_q.push_back(rd_exp_t'{addr: a, data: exp});
    @(posedge clk);
    #1;
    rd_chk = 1'b0;
  endtask

  task automatic expect_done();
    done_q.push_back(cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    reset      = 1'b1;
    pix_data   = '0;
    pix_valid  = 1'b0;
    pix_sof    = 1'b0;
    capture_en = 1'b0;
    rd_addr    = '0;
    #50;
    chk("rst_pix_ready", {31'd0, pix_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    chk("rst_frame_done", {31'd0, frame_done}, 0);
    chk("rst_rd_data", {24'd0, rd_data}, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("pix_ready_up", {31'd0, pix_ready}, 1);
    chk("idle_busy", {31'd0, busy}, 0);

    // Full frame, value = address low byte, SOF on first pixel.
    capture_en = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NPIX; i++) begin
      v = i[7:0];
      xfer(v, i == 0);
      if (i == 0) chk("busy_capture", {31'd0, busy}, 1);
      if (i == NPIX - 1) expect_done();
    end
    chk("busy_after_frame", {31'd0, busy}, 0);
    rd(16'h01FF, 8'hFF);
    rd(16'h0000, 8'h00);
    rd(16'h0080, 8'h80);

    // Junk before SOF, then a frame with a read-first collision at 5.
    for (int i = 0; i < 3; i++) xfer(8'hAA, 1'b0);
    chk("wait_sof_busy", {31'd0, busy}, 0);
    for (int i = 0; i < NPIX; i++) begin
      v = i[7:0] ^ 8'h55;
      if (i == 5) begin
        rd_addr = 16'd5;
        rd_chk  = 1'b1;
        rd_q.push_back(rd_exp_t'{addr: 16'd5, data: 8'h05});
      end
      if (i == 6) begin
        rd_chk = 1'b1;
        rd_q.push_back(rd_exp_t'{addr: 16'd5, data: 8'h50});
      end
      xfer(v, i == 0);
      if (i == 6) rd_chk = 1'b0;
      if (i == NPIX - 1) expect_done();
    end
    rd(16'd0, 8'h55);
    rd(16'd3, 8'h56);

    // Short frame: SOF after 100 pixels, then a full frame.
    for (int i = 0; i < 100; i++) xfer(8'h11, i == 0);
    chk("ovf_before", {31'd0, overflow}, 0);
    xfer(8'h77, 1'b1);
    chk("ovf_set", {31'd0, overflow}, 1);
    chk("ovf_busy", {31'd0, busy}, 1);
    for (int a = 1; a < NPIX; a++) begin
      v = a[7:0] + 8'h30;
      xfer(v, 1'b0);
      if (a == NPIX - 1) expect_done();
    end
    chk("ovf_sticky", {31'd0, overflow}, 1);
    rd(16'd0, 8'h77);
    rd(16'd1, 8'h31);
    rd(16'd99, 8'h93);
    rd(16'd100, 8'h94);

    // capture_en dropped mid-frame: frame still completes.
    for (int i = 0; i < NPIX; i++) begin
      if (i == 300) capture_en = 1'b0;
      v = ~i[7:0];
      xfer(v, i == 0);
      if (i == NPIX - 1) expect_done();
    end
    chk("drop_busy", {31'd0, busy}, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      xfer(8'h99, i == 0);
      if (i == 0) chk("idle_no_capture", {31'd0, busy}, 0);
    end
    rd(16'd0, 8'hFF);
    rd(16'd10, 8'hF5);
    rd(16'd300, 8'hD3);

    // Out-of-range reads return zero.
    rd(16'd512, 8'h00);
    rd(16'd61440, 8'h00);
    rd(16'hFFFF, 8'h00);

    // Reset at pixel 500 of a frame.
    capture_en = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 500; i++) xfer(8'h3C, i == 0);
    #5;
    reset = 1'b1;
    #5;
    chk("mid_rst_pix_ready", {31'd0, pix_ready}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_overflow", {31'd0, overflow}, 0);
    chk("mid_rst_frame_done", {31'd0, frame_done}, 0);
    chk("mid_rst_rd_data", {24'd0, rd_data}, 0);
    #10;
    reset      = 1'b0;
    capture_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_busy", {31'd0, busy}, 0);
    rd(16'd10, 8'h3C);
    rd(16'd499, 8'h3C);
    rd(16'd500, 8'h0B);
    rd(16'd505, 8'h06);

    repeat (3) @(posedge clk);
    #1;
    chk("rd_all_seen", rd_q.size(), 0);
    chk("done_all_seen", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
